// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the sequencer state encoding and the debug/status field widths.
package pll_rst_seq_pkg;

   localparam int SEQ_STATE_W = 3;
   localparam int LOCK_LOSS_W = 8;

   typedef enum logic [SEQ_STATE_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      DEBOUNCE  = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } seq_state_e;

   // PLL is held in reset while sequencing a reset pulse or parked after exhausting retries.
   function automatic logic drives_pll_rst(seq_state_e s);
      return (s == RESET_PLL) || (s == FAIL);
   endfunction

   function automatic logic holds_sys_reset(seq_state_e s);
      return s != RUN;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer (master) and the PLL wrapper / system (slave).
// Carries the lock indicator and soft restart in, PLL/system resets and debug status out.
interface pll_reset_sequencer_if;
   import pll_rst_seq_pkg::*;

   logic                   locked;
   logic                   soft_reset_req;
   logic                   pll_rst;
   logic                   sys_reset;
   logic                   pll_failed;
   logic [SEQ_STATE_W-1:0] seq_state;
   logic [LOCK_LOSS_W-1:0] lock_loss_count;

   modport master (
      input  locked, soft_reset_req,
      output pll_rst, sys_reset, pll_failed, seq_state, lock_loss_count
   );

   modport slave (
      output locked, soft_reset_req,
      input  pll_rst, sys_reset, pll_failed, seq_state, lock_loss_count
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level signal.
// Both stages clear to 0 while rst is high.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta and q shift on the same edge; blocking would collapse the two stages into one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, then releases sys_reset.
// Optional lock-loss event counter is built when PLL_RST_SEQ_LOCK_LOSS_CNT_EN is defined.
module pll_reset_sequencer
   import pll_rst_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1000,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 16
) (
   input  logic                         refclk,
   input  logic                         rst,
   pll_reset_sequencer_if.master        bus
);

   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               locked_s;
   logic               pll_rst_q, sys_reset_q, pll_failed_q;

   sync_2ff u_locked_sync (
      .clk (refclk),
      .rst (rst),
      .d   (bus.locked),
      .q   (locked_s)
   );

   // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;

      if (bus.soft_reset_req) begin
         state_d = RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            RESET_PLL: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = DEBOUNCE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + RETRY_W'(1);
                     state_d = RESET_PLL;
                  end else begin
                     state_d = FAIL;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DEBOUNCE: begin
               // A dropout restarts the lock wait but does not consume a retry.
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_d = RESET_PLL;
                  cnt_d   = '0;
                  retry_d = '0;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = RESET_PLL;
               cnt_d   = '0;
               retry_d = '0;
            end
         endcase
      end
   end

   // Outputs decode from next state so they move on the same edge as the state itself.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET_PLL;
         cnt_q        <= '0;
         retry_q      <= '0;
         pll_rst_q    <= 1'b1;
         sys_reset_q  <= 1'b1;
         pll_failed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         pll_rst_q    <= drives_pll_rst(state_d);
         sys_reset_q  <= holds_sys_reset(state_d);
         pll_failed_q <= (state_d == FAIL);
      end
   end

   assign bus.pll_rst    = pll_rst_q;
   assign bus.sys_reset  = sys_reset_q;
   assign bus.pll_failed = pll_failed_q;
   assign bus.seq_state  = state_q;

`ifdef PLL_RST_SEQ_LOCK_LOSS_CNT_EN
   logic                   lock_loss_evt;
   logic [LOCK_LOSS_W-1:0] lock_loss_q;

   // A soft reset taken in RUN is not a lock loss, even if lock also dropped that cycle.
   assign lock_loss_evt = (state_q == RUN) && !locked_s && !bus.soft_reset_req;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_loss_q <= '0;
      end else if (lock_loss_evt && (lock_loss_q != '1)) begin
         lock_loss_q <= lock_loss_q + LOCK_LOSS_W'(1);
      end
   end

   assign bus.lock_loss_count = lock_loss_q;
`else
   assign bus.lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters.
// Expected waveforms are computed from the sequencing rules as edge arithmetic.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;   // PLL_RST_CYCLES
   localparam int LTC = 20;  // LOCK_TIMEOUT_CYCLES
   localparam int LSC = 8;   // LOCK_STABLE_CYCLES
   localparam int MR  = 2;   // MAX_RETRIES

   localparam int S_RST = 0, S_WAIT = 1, S_DEB = 2, S_RUN = 3, S_FAIL = 4;

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   int   tests  = 0;
   int   fails  = 0;
   int   exp_loss = 0;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (PRC),
      .LOCK_TIMEOUT_CYCLES (LTC),
      .LOCK_STABLE_CYCLES  (LSC),
      .MAX_RETRIES         (MR),
      .CNT_W               (16)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus.master)
   );

   always #10 refclk = ~refclk;

   function automatic logic [5:0] obs();
      return {bus.seq_state, bus.pll_rst, bus.sys_reset, bus.pll_failed};
   endfunction

   // {state, pll_rst, sys_reset, pll_failed} as the output table gives them per state.
   function automatic logic [5:0] want(int st);
      logic p, s, f;
      p = (st == S_RST) || (st == S_FAIL);
      s = (st != S_RUN);
      f = (st == S_FAIL);
      return {3'(st), p, s, f};
   endfunction

   function automatic int bump_loss(int c);
`ifdef PLL_RST_SEQ_LOCK_LOSS_CNT_EN
      return (c >= 255) ? 255 : c + 1;
`else
      return 0;
`endif
   endfunction

   // Holds rst for two cycles and releases it on a falling edge; next rising edge is edge 1.
   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1;
      bus.locked = 1'b0;
      bus.soft_reset_req = 1'b0;
      exp_loss = 0;
      repeat (2) @(negedge refclk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.locked = 1'b0;
      bus.soft_reset_req = 1'b0;
      repeat (3) @(negedge refclk);
      tests++;
      if (obs() !== want(S_RST)) begin
         fails++;
         $display("FAIL reset_outputs got %b want %b", obs(), want(S_RST));
      end
      tests++;
      if (bus.lock_loss_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_loss_count got %0d want 0", bus.lock_loss_count);
      end
   endtask

   task automatic test_lock_normal();
      int d, n, st;
      d = $urandom_range(1, 10);
      n = PRC + 1 + d;
      do_reset();
      for (int k = 1; k <= n + LSC + 4; k++) begin
         @(negedge refclk);
         st = (k < PRC) ? S_RST : (k < n + 2) ? S_WAIT : (k < n + LSC + 2) ? S_DEB : S_RUN;
         tests++;
         if (obs() !== want(st)) begin
            fails++;
            $display("FAIL lock_normal d=%0d k=%0d got %b want %b", d, k, obs(), want(st));
         end
         if (k == PRC + d) bus.locked = 1'b1;
      end
   endtask

   // Starts in RUN with locked high; drops lock for L cycles each iteration.
   task automatic test_lock_loss(int iters);
      int len, dd, st;
      for (int it = 0; it < iters; it++) begin
         len = $urandom_range(1, 10);
         dd  = (len + 3 > PRC + 4) ? len + 3 : PRC + 4;
         @(negedge refclk);
         bus.locked = 1'b0;
         for (int j = 1; j <= dd + LSC + 2; j++) begin
            @(negedge refclk);
            st = (j < 3) ? S_RUN : (j < PRC + 3) ? S_RST : (j < dd) ? S_WAIT :
                 (j < dd + LSC) ? S_DEB : S_RUN;
            tests++;
            if (obs() !== want(st)) begin
               fails++;
               $display("FAIL lock_loss it=%0d len=%0d j=%0d got %b want %b", it, len, j, obs(), want(st));
            end
            if (j == len) bus.locked = 1'b1;
         end
         exp_loss = bump_loss(exp_loss);
         tests++;
         if (int'(bus.lock_loss_count) !== exp_loss) begin
            fails++;
            $display("FAIL lock_loss_count it=%0d got %0d want %0d", it, bus.lock_loss_count, exp_loss);
         end
      end
   endtask

   // From RUN: soft reset keeps the loss count; then rst mid-DEBOUNCE acts without a clock edge.
   task automatic test_async_reset();
      @(negedge refclk);
      bus.soft_reset_req = 1'b1;
      @(negedge refclk);
      bus.soft_reset_req = 1'b0;
      tests++;
      if (obs() !== want(S_RST) || int'(bus.lock_loss_count) !== exp_loss) begin
         fails++;
         $display("FAIL soft_from_run got %b/%0d want %b/%0d", obs(), bus.lock_loss_count, want(S_RST), exp_loss);
      end
      repeat (PRC + 3) @(negedge refclk);
      tests++;
      if (obs() !== want(S_DEB)) begin
         fails++;
         $display("FAIL reach_debounce got %b want %b", obs(), want(S_DEB));
      end
      #3 rst = 1'b1;
      #1;
      tests++;
      if (obs() !== want(S_RST) || bus.lock_loss_count !== 8'd0) begin
         fails++;
         $display("FAIL async_reset got %b/%0d want %b/0", obs(), bus.lock_loss_count, want(S_RST));
      end
      exp_loss = 0;
   endtask

   task automatic test_debounce_glitch();
      int d, n, e, c, st;
      d = $urandom_range(1, 8);
      c = $urandom_range(0, 5);
      n = PRC + 1 + d;
      e = n + 2;
      do_reset();
      for (int k = 1; k <= e + c + LSC + 6; k++) begin
         @(negedge refclk);
         st = (k < PRC) ? S_RST : (k < e) ? S_WAIT : (k < e + c + 3) ? S_DEB :
              (k < e + c + 4) ? S_WAIT : (k < e + c + 4 + LSC) ? S_DEB : S_RUN;
         tests++;
         if (obs() !== want(st)) begin
            fails++;
            $display("FAIL debounce_glitch c=%0d k=%0d got %b want %b", c, k, obs(), want(st));
         end
         if (k == PRC + d) bus.locked = 1'b1;
         if (k == e + c) bus.locked = 1'b0;
         if (k == e + c + 1) bus.locked = 1'b1;
      end
   endtask

   task automatic test_timeout_fail();
      int per, fail_k, st;
      per = PRC + LTC;
      fail_k = (MR + 1) * per;
      do_reset();
      for (int k = 1; k <= fail_k + 110; k++) begin
         @(negedge refclk);
         st = (k >= fail_k) ? S_FAIL : ((k % per) < PRC) ? S_RST : S_WAIT;
         tests++;
         if (obs() !== want(st)) begin
            fails++;
            $display("FAIL timeout_fail k=%0d got %b want %b", k, obs(), want(st));
         end
      end
   endtask

   // From FAIL: soft reset on the same cycle lock rises; lock is then already synchronized.
   task automatic test_fail_soft_reset();
      int st;
      @(negedge refclk);
      bus.soft_reset_req = 1'b1;
      bus.locked = 1'b1;
      @(negedge refclk);
      bus.soft_reset_req = 1'b0;
      for (int j = 0; j <= PRC + LSC + 4; j++) begin
         if (j > 0) @(negedge refclk);
         st = (j < PRC) ? S_RST : (j < PRC + 1) ? S_WAIT : (j < PRC + 1 + LSC) ? S_DEB : S_RUN;
         tests++;
         if (obs() !== want(st)) begin
            fails++;
            $display("FAIL fail_soft_reset j=%0d got %b want %b", j, obs(), want(st));
         end
      end
      tests++;
      if (int'(bus.lock_loss_count) !== exp_loss) begin
         fails++;
         $display("FAIL fail_soft_loss_count got %0d want %0d", bus.lock_loss_count, exp_loss);
      end
   endtask

   initial begin
      bus.locked = 1'b0;
      bus.soft_reset_req = 1'b0;
      test_reset();
      test_lock_normal();
      test_lock_loss($urandom_range(3, 5));
      test_lock_loss(260);
      test_async_reset();
      test_debounce_glitch();
      test_timeout_fail();
      test_fail_soft_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
